// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    // Scan phase of the current digit slot
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } scan_state_e;

    // Active-low drive patterns for a dark display
    localparam logic [6:0]            SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seven_seg_scan_ctrl_dec.sv
// Hex nibble to active-low seven-segment pattern (bit 0 = segment a).
module hex_to_seven_Seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure lookup; patterns are written active-high (gfedcba) then inverted
    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = ~7'h3F;
            4'h1: seg_o = ~7'h06;
            4'h2: seg_o = ~7'h5B;
            4'h3: seg_o = ~7'h4F;
            4'h4: seg_o = ~7'h66;
            4'h5: seg_o = ~7'h6D;
            4'h6: seg_o = ~7'h7D;
            4'h7: seg_o = ~7'h07;
            4'h8: seg_o = ~7'h7F;
            4'h9: seg_o = ~7'h6F;
            4'hA: seg_o = ~7'h77;
            4'hB: seg_o = ~7'h7C;
            4'hC: seg_o = ~7'h39;
            4'hD: seg_o = ~7'h5E;
            4'hE: seg_o = ~7'h79;
            4'hF: seg_o = ~7'h71;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode display scanner with a blanking
// guard between digits and frame-synchronous double-buffered updates.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [15:0]           value,
    input  logic [3:0]            dp_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    scan_state_e     state_q, state_d;
    logic [1:0]      digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [15:0]     disp_q, disp_d;
    logic [3:0]      disp_dp_q, disp_dp_d;
    logic [15:0]     shadow_q, shadow_d;
    logic [3:0]      shadow_dp_q, shadow_dp_d;
    logic            pending_q, pending_d;

    logic [6:0]      seg_q, seg_d;
    logic            dp_n_q, dp_n_d;
    logic [3:0]      an_q, an_d;
    logic            frame_done_q, frame_done_d;

    logic            slot_end;
    logic            frame_bnd;
    logic [3:0]      dec_nib;
    logic [6:0]      dec_seg;

    // A digit above 0 goes dark when it and every digit to its left are zero,
    // unless its decimal point is requested.
    function automatic logic digit_suppressed(input logic [15:0] v,
                                              input logic [3:0]  dp,
                                              input logic [1:0]  d,
                                              input logic        lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(d)) && (v[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        return lz && (d != 2'd0) && !dp[d] && upper_zero;
    endfunction

    assign slot_end  = (state_q == ST_ON) && (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign frame_bnd = slot_end && (digit_q == 2'd3);

    // Single shared decoder, steered by the digit index
    assign dec_nib = disp_q[{digit_q, 2'b00} +: 4];

    hex_to_seven_Seg u_dec (
        .hex_i (dec_nib),
        .seg_o (dec_seg)
    );

    // Slot sequencing: guard phase, lit phase, then advance or stop
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                cnt_d   = '0;
                digit_d = 2'd0;
                if (enable) begin
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GUARD - 1)) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (slot_end) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = ST_GUARD;
                        digit_d = digit_q + 2'd1;
                    end else begin
                        state_d = ST_OFF;
                        digit_d = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                digit_d = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Double buffer: host loads land in shadow, committed only at a frame
    // boundary, except when the display is dark or the load hits the boundary
    always_comb begin
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        if (frame_bnd && pending_q) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
            if (frame_bnd || (state_q == ST_OFF)) begin
                disp_d    = value;
                disp_dp_d = dp_in;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // Pin drives follow the current slot one cycle later; frame_done is
    // pre-computed so it is high during the last cycle of the frame
    always_comb begin
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        an_d   = AN_OFF;
        if (state_q != ST_OFF) begin
            seg_d  = dec_seg;
            dp_n_d = ~disp_dp_q[digit_q];
            if ((state_q == ST_ON) &&
                !digit_suppressed(disp_q, disp_dp_q, digit_q, lz_en)) begin
                an_d = ~(4'b0001 << digit_q);
            end
        end
        frame_done_d = (state_q == ST_ON) && (digit_q == 2'd3) &&
                       (cnt_q == CNT_W'(REFRESH_DIV - 2));
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OFF;
            digit_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
        end
    end

    // Display and shadow buffers
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q      <= '0;
            disp_dp_q   <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule
